// File: rtl/rom_row_reader_pkg.sv
// rtl/rom_row_reader_pkg.sv - shared widths and scan state type for the ROM row reader
package rom_row_reader_pkg;

  localparam int ROW_BITS  = 208;
  localparam int ADDR_BITS = 8;
  localparam int COL_BITS  = 8;

  // Column index of the final pixel in a row
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(ROW_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rom_row_reader_shifter.sv
// rtl/rom_row_reader_shifter.sv - row_shifter: 208-bit MSB-first pixel shift register with column counter
module row_shifter
  import rom_row_reader_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                advance,
  input  logic [ROW_BITS-1:0] row_in,
  output logic                bit_out,
  output logic [COL_BITS-1:0] column
);

  logic [ROW_BITS-1:0] sr;

  // Load a fresh row at column 0, or step one column toward the LSB end
  always_ff @(posedge clk) begin
    if (reset) begin
      sr     <= '0;
      column <= '0;
    end else if (load) begin
      sr     <= row_in;
      column <= '0;
    end else if (advance) begin
      sr     <= {sr[ROW_BITS-2:0], 1'b0};
      column <= column + 1'b1;
    end
  end

  // Column 0 is the row MSB, so the current pixel always sits at the top bit
  assign bit_out = sr[ROW_BITS-1];

endmodule

// File: rtl/rom_row_reader.sv
// rtl/rom_row_reader.sv - scans ROM rows first..last as a pixel stream; FRAME_LOOP_EN repeats the frame forever
module rom_row_reader
  import rom_row_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] row_first,
  input  logic [ADDR_BITS-1:0] row_last,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [ROW_BITS-1:0]  rom_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 pix_out,
  output logic [COL_BITS-1:0]  pix_x,
  output logic [ADDR_BITS-1:0] pix_y,
  output logic                 busy,
  output logic                 done
);

  state_t               state;
  logic [ADDR_BITS-1:0] last_addr;
`ifdef FRAME_LOOP_EN
  logic [ADDR_BITS-1:0] first_addr;
`endif
  logic                 xfer;
  logic                 row_end;
  logic                 load;
  logic                 advance;

  assign xfer    = pix_valid & pix_ready;
  assign row_end = (pix_x == LAST_COL);
  // ROM data for the new address is valid during the single FETCH cycle
  assign load    = (state == ST_FETCH);
  // The column holds at the last pixel; the next FETCH reloads it
  assign advance = xfer & ~row_end;

  row_shifter u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .row_in  (rom_data),
    .bit_out (pix_out),
    .column  (pix_x)
  );

  // Scan sequencing with registered address, row, valid, busy and done outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rom_addr  <= '0;
      last_addr <= '0;
`ifdef FRAME_LOOP_EN
      first_addr <= '0;
`endif
      pix_y     <= '0;
      pix_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rom_addr  <= row_first;
            last_addr <= row_last;
`ifdef FRAME_LOOP_EN
            first_addr <= row_first;
`endif
            busy      <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          pix_y     <= rom_addr;
          pix_valid <= 1'b1;
          state     <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (xfer && row_end) begin
            pix_valid <= 1'b0;
            if (rom_addr != last_addr) begin
              rom_addr <= rom_addr + 1'b1;
              state    <= ST_FETCH;
            end else begin
              done <= 1'b1;
`ifdef FRAME_LOOP_EN
              rom_addr <= first_addr;
              state    <= ST_FETCH;
`else
              state    <= ST_DONE;
`endif
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_row_reader.sv
// tb/tb_rom_row_reader.sv - self-checking bench for rom_row_reader against a pixel-cursor model
module tb_rom_row_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   row_first;
  logic [7:0]   row_last;
  logic [7:0]   rom_addr;
  logic [207:0] rom_data;
  logic         pix_valid;
  logic         pix_ready;
  logic         pix_out;
  logic [7:0]   pix_x;
  logic [7:0]   pix_y;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rom_row_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .row_first (row_first),
    .row_last  (row_last),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_out   (pix_out),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .busy      (busy),
    .done      (done)
  );

  // Row content: thirteen 16-bit chunks, chunk 12 is the MSB end
  function automatic logic [207:0] rom_row(input logic [7:0] a);
    logic [207:0] r;
    for (int i = 0; i < 13; i++)
      r[i*16 +: 16] = (16'(a) * 16'h9E37) ^ (16'(i) * 16'h7F4B) ^ 16'hA5C3;
    return r;
  endfunction

  assign rom_data = rom_row(rom_addr);

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Model: a pixel cursor walking rows first..last (mod 256), 208 columns each
  int         m_state = 0;   // 0 idle, 1 scanning, 2 done cycle expected
  bit         m_done_exp = 1'b0;
  int         m_x = 0;
  logic [7:0] m_y = '0;
  logic [7:0] m_first = '0;
  logic [7:0] m_last = '0;

  always @(negedge clk) begin
    logic [207:0] r;
    if (reset) begin
      m_state    = 0;
      m_done_exp = 1'b0;
    end else begin
      case (m_state)
        0: begin
          chk("idle_busy", int'(busy), 0);
          chk("idle_valid", int'(pix_valid), 0);
          chk("idle_done", int'(done), 0);
          if (start) begin
            m_state = 1;
            m_x     = 0;
            m_y     = row_first;
            m_first = row_first;
            m_last  = row_last;
          end
        end
        1: begin
          chk("scan_busy", int'(busy), 1);
          chk("scan_done", int'(done), int'(m_done_exp));
          m_done_exp = 1'b0;
          if (pix_valid) begin
            r = rom_row(m_y);
            chk("pix_x", int'(pix_x), m_x);
            chk("pix_y", int'(pix_y), int'(m_y));
            chk("pix_out", int'(pix_out), int'(r[207 - m_x]));
            if (pix_ready) begin
              m_x++;
              if (m_x == 208) begin
                m_x = 0;
                if (m_y == m_last) begin
`ifdef FRAME_LOOP_EN
                  m_y        = m_first;
                  m_done_exp = 1'b1;
`else
                  m_state = 2;
`endif
                end else begin
                  m_y = m_y + 8'd1;
                end
              end
            end
          end
        end
        default: begin
          chk("done_pulse", int'(done), 1);
          chk("done_busy", int'(busy), 1);
          chk("done_valid", int'(pix_valid), 0);
          m_state = 0;
        end
      endcase
    end
  end

  logic [7:0] addr_q[$];

  task automatic start_scan(input logic [7:0] f, input logic [7:0] l);
    @(posedge clk); #1;
    row_first = f;
    row_last  = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Runs one scan to IDLE; rnd randomises pix_ready, poke pulses a stray start mid-scan
  task automatic run_scan(input int max_cyc, input bit rnd, input bit poke,
                          output int n_xfer, output int n_done, output int n_gap,
                          output int n_busy, output logic [207:0] cap);
    bit seen = 1'b0;
    bit ok   = 1'b0;
    n_xfer = 0; n_done = 0; n_gap = 0; n_busy = 0; cap = '0;
    addr_q.delete();
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (busy) n_busy++;
      if (busy && !pix_valid && !done) begin
        n_gap++;
        addr_q.push_back(rom_addr);
      end
      if (pix_valid && pix_ready) begin
        cap = {cap[206:0], pix_out};
        n_xfer++;
      end
      if (done) begin
        n_done++;
        seen = 1'b1;
      end
      if (seen && !busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start     = poke && (c == 50);
      if (poke && c == 50) row_first = 8'd0;
    end
    start     = 1'b0;
    pix_ready = 1'b1;
    chk("scan_timeout", int'(ok), 1);
  endtask

  initial begin
    int x, d, g, b;
    logic [207:0] cap;
    reset = 1'b1; start = 1'b0; row_first = '0; row_last = '0; pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_pix_x", int'(pix_x), 0);
    chk("rst_pix_y", int'(pix_y), 0);
    chk("rst_pix_out", int'(pix_out), 0);
    chk("rst_valid", int'(pix_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

`ifdef FRAME_LOOP_EN
    begin
      int last_d = -1, dn = 0, iv1 = 0, iv2 = 0, low = 0;
      start_scan(8'd5, 8'd5);
      for (int c = 0; c < 700; c++) begin
        @(negedge clk);
        if (!busy) low++;
        if (done) begin
          dn++;
          if (dn == 2) iv1 = c - last_d;
          if (dn == 3) iv2 = c - last_d;
          last_d = c;
        end
      end
      chk("loop_done_count", dn, 3);
      chk("loop_interval1", iv1, 209);
      chk("loop_interval2", iv2, 209);
      chk("loop_busy_low", low, 0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
    end
`else
    // Single row 123
    start_scan(8'd123, 8'd123);
    run_scan(1000, 1'b0, 1'b0, x, d, g, b, cap);
    chk("r123_fetch_addr", int'(addr_q[0]), 123);
    chk("r123_xfers", x, 208);
    chk("r123_done", d, 1);
    chk("r123_busy_cycles", b, 210);
    chk("r123_head_bits", int'(cap[207:204]), 5);
    chk("r123_row", int'(cap == rom_row(8'd123)), 1);
    chk("r123_busy_after", int'(busy), 0);

    // Rows 68..69 with a stray start mid-scan
    start_scan(8'd68, 8'd69);
    run_scan(1000, 1'b0, 1'b1, x, d, g, b, cap);
    chk("r68_xfers", x, 416);
    chk("r68_fetches", g, 2);
    chk("r68_busy_cycles", b, 419);
    chk("r68_done", d, 1);
    chk("r68_addr0", int'(addr_q[0]), 68);
    chk("r68_addr1", int'(addr_q[1]), 69);

    // Wrap 255 -> 0
    start_scan(8'd255, 8'd0);
    run_scan(1000, 1'b0, 1'b0, x, d, g, b, cap);
    chk("wrap_xfers", x, 416);
    chk("wrap_done", d, 1);
    chk("wrap_addr0", int'(addr_q[0]), 255);
    chk("wrap_addr1", int'(addr_q[1]), 0);

    // Row 69 with random back-pressure
    start_scan(8'd69, 8'd69);
    run_scan(3000, 1'b1, 1'b0, x, d, g, b, cap);
    chk("r69_xfers", x, 208);
    chk("r69_row", int'(cap == rom_row(8'd69)), 1);

    // Abort at column 100
    start_scan(8'd10, 8'd12);
    begin
      bit hit = 1'b0;
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        if (pix_valid && pix_x == 8'd100) begin
          hit = 1'b1;
          break;
        end
      end
      chk("abort_reach_col100", int'(hit), 1);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_rom_addr", int'(rom_addr), 0);
    chk("abort_pix_x", int'(pix_x), 0);
    chk("abort_pix_y", int'(pix_y), 0);
    chk("abort_pix_out", int'(pix_out), 0);
    chk("abort_valid", int'(pix_valid), 0);
    chk("abort_busy", int'(busy), 0);
    begin
      int dn = 0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (done) dn++;
      end
      chk("abort_no_done", dn, 0);
    end

    // Fresh scan after abort
    start_scan(8'd200, 8'd200);
    run_scan(1000, 1'b0, 1'b0, x, d, g, b, cap);
    chk("restart_xfers", x, 208);
    chk("restart_done", d, 1);
    chk("restart_row", int'(cap == rom_row(8'd200)), 1);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
